score_reducer: RTL and testbench

SCORE_REDUCER -- requirements
Module: score_reducer

---
 rtl/score_reducer.sv | 76 +++++++
 tb/tb_score_reducer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/score_reducer.sv
// score_reducer: streaming max-reduction of predecessor chain scores f(j)+gap for one anchor.
// Define SCORE_REDUCER_SAT_EN to saturate the candidate sum instead of wrapping.
module score_reducer #(
    parameter int IDXW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [IDXW-1:0] n_pred,
    input  logic [31:0]     init_score,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_score,
    input  logic [31:0]     in_fj,
    input  logic [IDXW-1:0] in_idx,
    output logic            busy,
    output logic            done,
    output logic [31:0]     best_score,
    output logic [IDXW-1:0] best_idx,
    output logic            best_found
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    logic [1:0]      state;
    logic [IDXW-1:0] count;
    logic [IDXW-1:0] n_q;
    logic [32:0]     sum;
    logic [31:0]     cand;
    logic            accept;
    logic            last;
    always_comb sum = {in_fj[31], in_fj} + {in_score[31], in_score};
`ifdef SCORE_REDUCER_SAT_EN
    always_comb cand = (sum[32] != sum[31]) ? (sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF) : sum[31:0];
`else
    always_comb cand = sum[31:0];
`endif
    assign in_ready = state == ACCUM;
    assign busy     = state == ACCUM;
    assign done     = state == DONE;
    assign accept   = in_valid && in_ready;
    // Compare against n-1 so n_pred = 2^IDXW-1 never needs the count to wrap
    assign last     = count == n_q - IDXW'(1);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            count      <= '0;
            n_q        <= '0;
            best_score <= '0;
            best_idx   <= '0;
            best_found <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    best_score <= init_score;
                    best_idx   <= '0;
                    best_found <= 1'b0;
                    count      <= '0;
                    n_q        <= n_pred;
                    state      <= (n_pred == '0) ? DONE : ACCUM;
                end
                ACCUM: if (accept) begin
                    if ($signed(cand) > $signed(best_score)) begin
                        best_score <= cand;
                        best_idx   <= in_idx;
                        best_found <= 1'b1;
                    end
                    count <= count + IDXW'(1);
                    if (last) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_score_reducer.sv
// tb_score_reducer: directed table-driven checks of score_reducer plus hand-written
// sequences for in_valid gaps, ignored start, max n_pred and asynchronous reset.
module tb_score_reducer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  n_pred = '0;
    logic [31:0] init_score = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_score = '0;
    logic [31:0] in_fj = '0;
    logic [7:0]  in_idx = '0;
    logic        busy;
    logic        done;
    logic [31:0] best_score;
    logic [7:0]  best_idx;
    logic        best_found;
    int          passed = 0;
    int          total = 0;
    int          done_cnt = 0;

    score_reducer #(.IDXW(8)) dut (
        .clk(clk), .reset(reset), .start(start), .n_pred(n_pred), .init_score(init_score),
        .in_valid(in_valid), .in_ready(in_ready), .in_score(in_score), .in_fj(in_fj),
        .in_idx(in_idx), .busy(busy), .done(done), .best_score(best_score),
        .best_idx(best_idx), .best_found(best_found)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (done) done_cnt++;

    typedef struct {
        logic [7:0]       n;
        logic [31:0]      init;
        logic [2:0][31:0] fj;
        logic [2:0][31:0] sc;
        logic [2:0][7:0]  idx;
        logic [31:0]      e_score;
        logic [7:0]       e_idx;
        logic             e_found;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_red(input logic [7:0] n, input logic [31:0] init);
        start = 1'b1;
        n_pred = n;
        init_score = init;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [31:0] fj, input logic [31:0] sc, input logic [7:0] idx);
        int t;
        logic acc;
        t = 0;
        acc = 1'b0;
        in_valid = 1'b1;
        in_fj = fj;
        in_score = sc;
        in_idx = idx;
        while (!acc && t < 20) begin
            acc = in_ready;
            tick();
            t++;
        end
        in_valid = 1'b0;
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic chk_result(input string tag, input logic [31:0] s, input logic [7:0] i, input logic f);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_score"}, best_score, s);
        chk({tag, "_idx"}, 32'(best_idx), 32'(i));
        chk({tag, "_found"}, 32'(best_found), 32'(f));
    endtask

    initial begin
        vecs[0] = '{8'd3, 32'd10, {32'd25, 32'd30, 32'd20}, {-32'sd2, -32'sd10, -32'sd5},
                    {8'd9, 8'd7, 8'd4}, 32'd23, 8'd9, 1'b1};
        vecs[1] = '{8'd0, -32'sd7, '0, '0, '0, -32'sd7, 8'd0, 1'b0};
        vecs[2] = '{8'd2, 32'd5, {32'd0, 32'd4, 32'd3}, {32'd0, 32'd1, 32'd2},
                    {8'd0, 8'd2, 8'd1}, 32'd5, 8'd0, 1'b0};
        vecs[3] = '{8'd2, 32'd0, {32'd0, 32'd4, 32'd3}, {32'd0, 32'd1, 32'd2},
                    {8'd0, 8'd2, 8'd1}, 32'd5, 8'd1, 1'b1};
        vecs[4] = '{8'd3, -32'sd100, {-32'sd30, -32'sd20, -32'sd50}, {32'd0, -32'sd5, -32'sd10},
                    {8'd8, 8'd6, 8'd3}, -32'sd25, 8'd6, 1'b1};
`ifdef SCORE_REDUCER_SAT_EN
        vecs[5] = '{8'd1, 32'd0, {64'd0, 32'h7FFF_FFF0}, {64'd0, 32'h20}, {16'd0, 8'd5},
                    32'h7FFF_FFFF, 8'd5, 1'b1};
        vecs[6] = '{8'd1, 32'd0, {64'd0, 32'h8000_0000}, {64'd0, 32'hFFFF_FFFF}, {16'd0, 8'd2},
                    32'd0, 8'd0, 1'b0};
`else
        vecs[5] = '{8'd1, 32'd0, {64'd0, 32'h7FFF_FFF0}, {64'd0, 32'h20}, {16'd0, 8'd5},
                    32'd0, 8'd0, 1'b0};
        vecs[6] = '{8'd1, 32'd0, {64'd0, 32'h8000_0000}, {64'd0, 32'hFFFF_FFFF}, {16'd0, 8'd2},
                    32'h7FFF_FFFF, 8'd2, 1'b1};
`endif
        #3;
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_score", best_score, 32'd0);
        tick();
        reset = 1'b1;
        tick();

        for (int v = 0; v < 7; v++) begin
            start_red(vecs[v].n, vecs[v].init);
            if (vecs[v].n != 0) begin
                chk($sformatf("v%0d_busy", v), 32'(busy), 32'd1);
                chk($sformatf("v%0d_init", v), best_score, vecs[v].init);
                for (int b = 0; b < int'(vecs[v].n); b++) begin
                    if (b > 0) chk($sformatf("v%0d_early_done", v), 32'(done), 32'd0);
                    send(vecs[v].fj[b], vecs[v].sc[b], vecs[v].idx[b]);
                end
            end else chk($sformatf("v%0d_ready", v), 32'(in_ready), 32'd0);
            chk_result($sformatf("v%0d", v), vecs[v].e_score, vecs[v].e_idx, vecs[v].e_found);
            tick();
            chk($sformatf("v%0d_pulse", v), 32'(done), 32'd0);
            chk($sformatf("v%0d_hold", v), best_score, vecs[v].e_score);
        end

        // beats offered in IDLE must be ignored
        in_valid = 1'b1;
        in_fj = 32'd1000;
        in_score = 32'd0;
        in_idx = 8'd77;
        chk("idle_ready", 32'(in_ready), 32'd0);
        tick();
        tick();
        in_valid = 1'b0;
        chk("idle_score", best_score, vecs[6].e_score);
        chk("idle_idx", 32'(best_idx), 32'(vecs[6].e_idx));

        // gaps plus an ignored mid-ACCUM start
        start_red(8'd2, 32'd0);
        repeat (3) tick();
        send(32'd10, 32'd0, 8'd3);
        tick();
        start = 1'b1;
        n_pred = 8'd1;
        init_score = 32'd1000;
        tick();
        start = 1'b0;
        tick();
        chk("gap_no_done", 32'(done), 32'd0);
        chk("gap_busy", 32'(busy), 32'd1);
        send(32'd20, 32'd0, 8'd4);
        chk_result("gap", 32'd20, 8'd4, 1'b1);
        tick();

        // maximum n_pred: exactly 255 beats, no count wrap
        start_red(8'd255, 32'd0);
        for (int b = 0; b < 255; b++) begin
            if (b == 254) chk("max_early_done", 32'(done), 32'd0);
            send(32'(b), 32'd0, 8'(b));
        end
        chk_result("max", 32'd254, 8'd254, 1'b1);
        tick();

        // asynchronous reset mid-ACCUM
        start_red(8'd4, 32'd0);
        send(32'd50, 32'd0, 8'd6);
        done_cnt = 0;
        #2;
        reset = 1'b0;
        #1;
        chk("arst_ready", 32'(in_ready), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_score", best_score, 32'd0);
        chk("arst_idx", 32'(best_idx), 32'd0);
        chk("arst_found", 32'(best_found), 32'd0);
        tick();
        reset = 1'b1;
        repeat (4) tick();
        chk("arst_no_done", 32'(done_cnt), 32'd0);
        start_red(8'd1, 32'd3);
        send(32'd4, 32'd1, 8'd11);
        chk_result("post_rst", 32'd5, 8'd11, 1'b1);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
